// File: rtl/bus_port_pkg.sv
// Shared types and constants for the per-terminal bus port: destination ID,
// saturating statistics counter and FIFO occupancy states.
package bus_port_pkg;

   localparam int ID_W = 8;

   typedef logic [ID_W-1:0] dest_id_t;
   typedef logic [15:0]     stat_cnt_t;

   localparam dest_id_t  BROADCAST = 8'hFF;
   localparam stat_cnt_t STAT_MAX  = 16'hFFFF;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_e;

   function automatic stat_cnt_t sat_inc(input stat_cnt_t v);
      return (v == STAT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/bus_fifo_core.sv
// First-word-fall-through FIFO used for both the TX and RX queues of a bus port.
// Head data is read combinationally; full/empty come from a registered occupancy state.
//
// state       | meaning
// OCC_EMPTY   | no entries, head data is don't-care
// OCC_PARTIAL | 1 .. DEPTH-1 entries
// OCC_FULL    | DEPTH entries, writes only accepted with a same-cycle read
module bus_fifo_core
   import bus_port_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_drop,
   input  logic                     rd,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_nxt;
   occ_e             occ_q;
   occ_e             occ_nxt;
   logic             do_wr;
   logic             do_rd;

   // A read frees a slot in the same cycle, so a full FIFO can take a write alongside it.
   assign do_rd   = rd && (occ_q != OCC_EMPTY);
   assign do_wr   = wr && ((occ_q != OCC_FULL) || do_rd);
   assign wr_drop = wr && !do_wr;

   always_comb begin
      cnt_nxt = cnt_q;
      case ({do_wr, do_rd})
         2'b10:   cnt_nxt = cnt_q + CW'(1);
         2'b01:   cnt_nxt = cnt_q - CW'(1);
         default: cnt_nxt = cnt_q;
      endcase
   end

   always_comb begin
      occ_nxt = OCC_PARTIAL;
      if (cnt_nxt == '0) begin
         occ_nxt = OCC_EMPTY;
      end else if (cnt_nxt == DEPTH_C) begin
         occ_nxt = OCC_FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
         occ_q  <= OCC_EMPTY;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         cnt_q <= cnt_nxt;
         occ_q <= occ_nxt;
      end
   end

   // Storage is never cleared; a write in a reset cycle is discarded.
   always_ff @(posedge clk) begin
      if (do_wr && !reset) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (occ_q == OCC_FULL);
   assign empty   = (occ_q == OCC_EMPTY);
   assign count   = cnt_q;

endmodule

// File: rtl/bus_port_fifo.sv
// Per-terminal bus port: TX queue toward the arbiter, destination-filtered RX queue
// toward the endpoint. Drop/misroute counters exist only when BUS_PORT_STATS_EN is defined.
module bus_port_fifo
   import bus_port_pkg::*;
#(
   parameter int       pckg_sz   = 16,
   parameter int       depth     = 8,
   parameter dest_id_t id        = 8'h00,
   parameter dest_id_t broadcast = BROADCAST
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [pckg_sz-1:0] wr_data,
   output logic               tx_full,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   input  logic               rx_rd,
   output logic               rx_valid,
   output logic [pckg_sz-1:0] rx_data,
   output logic [15:0]        tx_ovf_cnt,
   output logic [15:0]        rx_ovf_cnt,
   output logic [15:0]        misroute_cnt
);

   localparam int CW = $clog2(depth) + 1;

   logic          tx_empty;
   logic          tx_drop;
   logic [CW-1:0] tx_count;
   logic          rx_empty;
   logic          rx_full;
   logic          rx_drop;
   logic [CW-1:0] rx_count;
   dest_id_t      rx_dest;
   logic          rx_match;
   logic          rx_wr;
   logic          misroute;
   logic          unused_occ;

   assign rx_dest  = D_push[pckg_sz-1 -: ID_W];
   assign rx_match = (rx_dest == id) || (rx_dest == broadcast);
   assign rx_wr    = push && rx_match;
   assign misroute = push && !rx_match;

   bus_fifo_core #(
      .WIDTH (pckg_sz),
      .DEPTH (depth)
   ) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr_en),
      .wr_data (wr_data),
      .wr_drop (tx_drop),
      .rd      (pop),
      .rd_data (D_pop),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   bus_fifo_core #(
      .WIDTH (pckg_sz),
      .DEPTH (depth)
   ) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (rx_wr),
      .wr_data (D_push),
      .wr_drop (rx_drop),
      .rd      (rx_rd),
      .rd_data (rx_data),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

   assign pndng      = !tx_empty;
   assign rx_valid   = !rx_empty;
   assign unused_occ = ^{tx_count, rx_count, rx_full};

`ifdef BUS_PORT_STATS_EN
   stat_cnt_t tx_ovf_q;
   stat_cnt_t rx_ovf_q;
   stat_cnt_t misroute_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_ovf_q   <= '0;
         rx_ovf_q   <= '0;
         misroute_q <= '0;
      end else begin
         if (tx_drop) begin
            tx_ovf_q <= sat_inc(tx_ovf_q);
         end
         if (rx_drop) begin
            rx_ovf_q <= sat_inc(rx_ovf_q);
         end
         if (misroute) begin
            misroute_q <= sat_inc(misroute_q);
         end
      end
   end

   assign tx_ovf_cnt   = tx_ovf_q;
   assign rx_ovf_cnt   = rx_ovf_q;
   assign misroute_cnt = misroute_q;
`else
   logic unused_drop;

   assign unused_drop  = ^{tx_drop, rx_drop, misroute};
   assign tx_ovf_cnt   = '0;
   assign rx_ovf_cnt   = '0;
   assign misroute_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_port_fifo.sv
// Self-checking bench for bus_port_fifo: directed vector table, corner-case sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_bus_port_fifo;

   localparam int        W     = 16;
   localparam int        DEPTH = 8;
   localparam logic [7:0] ID   = 8'h02;
`ifdef BUS_PORT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         wr_en;
   logic [W-1:0] wr_data;
   logic         tx_full;
   logic         pndng;
   logic [W-1:0] D_pop;
   logic         pop;
   logic         push;
   logic [W-1:0] D_push;
   logic         rx_rd;
   logic         rx_valid;
   logic [W-1:0] rx_data;
   logic [15:0]  tx_ovf_cnt;
   logic [15:0]  rx_ovf_cnt;
   logic [15:0]  misroute_cnt;

   always #5 clk = ~clk;

   bus_port_fifo #(
      .pckg_sz   (W),
      .depth     (DEPTH),
      .id        (ID),
      .broadcast (8'hFF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .tx_full      (tx_full),
      .pndng        (pndng),
      .D_pop        (D_pop),
      .pop          (pop),
      .push         (push),
      .D_push       (D_push),
      .rx_rd        (rx_rd),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .tx_ovf_cnt   (tx_ovf_cnt),
      .rx_ovf_cnt   (rx_ovf_cnt),
      .misroute_cnt (misroute_cnt)
   );

   typedef struct packed {
      logic         rst;
      logic         wr_en;
      logic [W-1:0] wr_data;
      logic         pop;
      logic         push;
      logic [W-1:0] d_push;
      logic         rx_rd;
   } in_t;

   typedef struct {
      in_t          in;
      logic         pndng;
      logic         tx_full;
      logic         rx_valid;
      logic [W-1:0] d_pop;
      logic [W-1:0] rx_data;
      int           tx_ovf;
      int           rx_ovf;
      int           mis;
   } vec_t;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [W-1:0] mtx[$];
   logic [W-1:0] mrx[$];
   int           m_txovf = 0;
   int           m_rxovf = 0;
   int           m_mis   = 0;

   function automatic in_t mk(input logic rst, input logic we, input logic [W-1:0] wd,
                              input logic pp, input logic ps, input logic [W-1:0] dp,
                              input logic rd);
      in_t v;
      v.rst = rst; v.wr_en = we; v.wr_data = wd; v.pop = pp;
      v.push = ps; v.d_push = dp; v.rx_rd = rd;
      return v;
   endfunction

   function automatic int sat(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   function automatic int cexp(input int v);
      return STATS ? v : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: packet queues plus drop/filter rules, advanced once per edge.
   task automatic model_update(input in_t v);
      bit tpop, twr, rpop, rwr, match;
      if (v.rst) begin
         mtx.delete(); mrx.delete();
         m_txovf = 0; m_rxovf = 0; m_mis = 0;
      end else begin
         tpop = v.pop && (mtx.size() > 0);
         twr  = v.wr_en && ((mtx.size() < DEPTH) || tpop);
         if (tpop) void'(mtx.pop_front());
         if (twr) mtx.push_back(v.wr_data);
         else if (v.wr_en) m_txovf = sat(m_txovf);
         match = (v.d_push[15:8] == ID) || (v.d_push[15:8] == 8'hFF);
         if (v.push && !match) m_mis = sat(m_mis);
         rpop = v.rx_rd && (mrx.size() > 0);
         rwr  = v.push && match && ((mrx.size() < DEPTH) || rpop);
         if (rpop) void'(mrx.pop_front());
         if (rwr) mrx.push_back(v.d_push);
         else if (v.push && match) m_rxovf = sat(m_rxovf);
      end
   endtask

   task automatic step(input in_t v);
      reset = v.rst; wr_en = v.wr_en; wr_data = v.wr_data; pop = v.pop;
      push = v.push; D_push = v.d_push; rx_rd = v.rx_rd;
      @(posedge clk);
      model_update(v);
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      chk({tag, ":pndng"},    pndng,    mtx.size() != 0);
      chk({tag, ":tx_full"},  tx_full,  mtx.size() == DEPTH);
      chk({tag, ":rx_valid"}, rx_valid, mrx.size() != 0);
      if (mtx.size() > 0) chk({tag, ":D_pop"}, D_pop, mtx[0]);
      if (mrx.size() > 0) chk({tag, ":rx_data"}, rx_data, mrx[0]);
      chk({tag, ":tx_ovf"},   tx_ovf_cnt,   cexp(m_txovf));
      chk({tag, ":rx_ovf"},   rx_ovf_cnt,   cexp(m_rxovf));
      chk({tag, ":misroute"}, misroute_cnt, cexp(m_mis));
   endtask

   task automatic run(input in_t v, input string tag);
      step(v);
      check_model(tag);
   endtask

   vec_t tbl[13];
   in_t  idle;

   initial begin
      idle = mk(0, 0, 16'h0, 0, 0, 16'h0, 0);
      reset = 1'b1; wr_en = 1'b0; wr_data = '0; pop = 1'b0;
      push = 1'b0; D_push = '0; rx_rd = 1'b0;
      @(negedge clk);

      // ---------------- directed vector table ----------------
      //             in                                              pnd ful rxv d_pop    rx_data  txo rxo mis
      tbl[0]  = '{mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0),          0,  0,  0, 16'h0000, 16'h0000, 0, 0, 0};
      tbl[1]  = '{mk(0, 1, 16'h0305, 0, 0, 16'h0000, 0),          1,  0,  0, 16'h0305, 16'h0000, 0, 0, 0};
      tbl[2]  = '{mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0),          0,  0,  0, 16'h0000, 16'h0000, 0, 0, 0};
      tbl[3]  = '{mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0),          0,  0,  0, 16'h0000, 16'h0000, 0, 0, 0};
      tbl[4]  = '{mk(0, 0, 16'h0000, 0, 1, 16'h0211, 0),          0,  0,  1, 16'h0000, 16'h0211, 0, 0, 0};
      tbl[5]  = '{mk(0, 0, 16'h0000, 0, 1, 16'hFF22, 0),          0,  0,  1, 16'h0000, 16'h0211, 0, 0, 0};
      tbl[6]  = '{mk(0, 0, 16'h0000, 0, 1, 16'h0533, 0),          0,  0,  1, 16'h0000, 16'h0211, 0, 0, 1};
      tbl[7]  = '{mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1),          0,  0,  1, 16'h0000, 16'hFF22, 0, 0, 1};
      tbl[8]  = '{mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1),          0,  0,  0, 16'h0000, 16'h0000, 0, 0, 1};
      tbl[9]  = '{mk(0, 1, 16'h0A01, 1, 0, 16'h0000, 0),          1,  0,  0, 16'h0A01, 16'h0000, 0, 0, 1};
      tbl[10] = '{mk(0, 1, 16'h0A02, 0, 1, 16'h0277, 1),          1,  0,  1, 16'h0A01, 16'h0277, 0, 0, 1};
      tbl[11] = '{mk(0, 0, 16'h0000, 1, 1, 16'h02AA, 1),          1,  0,  1, 16'h0A02, 16'h02AA, 0, 0, 1};
      tbl[12] = '{mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1),          0,  0,  0, 16'h0000, 16'h0000, 0, 0, 1};

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].in);
         chk($sformatf("vec%0d:pndng", i),    pndng,    tbl[i].pndng);
         chk($sformatf("vec%0d:tx_full", i),  tx_full,  tbl[i].tx_full);
         chk($sformatf("vec%0d:rx_valid", i), rx_valid, tbl[i].rx_valid);
         if (tbl[i].pndng)    chk($sformatf("vec%0d:D_pop", i),   D_pop,   tbl[i].d_pop);
         if (tbl[i].rx_valid) chk($sformatf("vec%0d:rx_data", i), rx_data, tbl[i].rx_data);
         chk($sformatf("vec%0d:tx_ovf", i),   tx_ovf_cnt,   cexp(tbl[i].tx_ovf));
         chk($sformatf("vec%0d:rx_ovf", i),   rx_ovf_cnt,   cexp(tbl[i].rx_ovf));
         chk($sformatf("vec%0d:misroute", i), misroute_cnt, cexp(tbl[i].mis));
      end

      // ---------------- TX overflow and pointer wrap ----------------
      for (int i = 0; i < 10; i++) begin
         run(mk(0, 1, 16'h0100 + 16'(i), 0, 0, 16'h0, 0), "txovf_wr");
         if (i == 6) chk("txovf_not_full_at7", tx_full, 1'b0);
         if (i == 7) chk("txovf_full_at8", tx_full, 1'b1);
      end
      chk("txovf_cnt", tx_ovf_cnt, STATS ? 16'd2 : 16'd0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("txovf_order%0d", i), D_pop, 16'h0100 + 16'(i));
         run(mk(0, 0, 16'h0, 1, 0, 16'h0, 0), "txovf_pop");
      end
      chk("txovf_drained", pndng, 1'b0);

      // ---------------- simultaneous write+pop when full ----------------
      for (int i = 0; i < 8; i++) run(mk(0, 1, 16'h0300 + 16'(i), 0, 0, 16'h0, 0), "simul_fill");
      run(mk(0, 1, 16'h03EE, 1, 0, 16'h0, 0), "simul_wrpop");
      chk("simul_full_held", tx_full, 1'b1);
      chk("simul_ovf_same", tx_ovf_cnt, STATS ? 16'd2 : 16'd0);
      chk("simul_new_head", D_pop, 16'h0301);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("simul_last", D_pop, 16'h03EE);
         run(mk(0, 0, 16'h0, 1, 0, 16'h0, 0), "simul_pop");
      end

      // ---------------- RX overflow ----------------
      for (int i = 0; i < 9; i++) run(mk(0, 0, 16'h0, 0, 1, 16'h0240 + 16'(i), 0), "rxovf_push");
      chk("rxovf_cnt", rx_ovf_cnt, STATS ? 16'd1 : 16'd0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rxovf_order%0d", i), rx_data, 16'h0240 + 16'(i));
         run(mk(0, 0, 16'h0, 0, 0, 16'h0, 1), "rxovf_rd");
      end
      chk("rxovf_drained", rx_valid, 1'b0);

      // ---------------- reset mid-operation ----------------
      run(mk(0, 0, 16'h0, 0, 1, 16'h0599, 0), "rst_pre_mis");
      for (int i = 0; i < 5; i++)
         run(mk(0, 1, 16'h0B00 + 16'(i), 0, (i < 3), 16'h0260 + 16'(i), 0), "rst_fill");
      step(mk(1, 1, 16'h0BAD, 0, 1, 16'h02BE, 0));
      chk("rst_pndng", pndng, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_tx_full", tx_full, 1'b0);
      chk("rst_tx_ovf", tx_ovf_cnt, 16'd0);
      chk("rst_rx_ovf", rx_ovf_cnt, 16'd0);
      chk("rst_misroute", misroute_cnt, 16'd0);
      run(idle, "rst_after");
      chk("rst_nothing_tx", pndng, 1'b0);
      chk("rst_nothing_rx", rx_valid, 1'b0);

      // ---------------- randomized traffic ----------------
      begin
         int wr_pct, pop_pct, push_pct, rd_pct;
         logic [7:0] dst;
         in_t v;
         wr_pct = 50; pop_pct = 50; push_pct = 50; rd_pct = 50;
         for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
               wr_pct   = $urandom_range(10, 95);
               pop_pct  = $urandom_range(10, 95);
               push_pct = $urandom_range(10, 95);
               rd_pct   = $urandom_range(10, 95);
            end
            case ($urandom_range(0, 3))
               0:       dst = ID;
               1:       dst = 8'hFF;
               2:       dst = 8'($urandom);
               default: dst = ID;
            endcase
            v = mk($urandom_range(0, 199) == 0,
                   $urandom_range(0, 99) < wr_pct, 16'($urandom),
                   $urandom_range(0, 99) < pop_pct,
                   $urandom_range(0, 99) < push_pct, {dst, 8'($urandom)},
                   $urandom_range(0, 99) < rd_pct);
            run(v, "rand");
         end
      end

      // ---------------- counter saturation ----------------
      step(mk(1, 0, 16'h0, 0, 0, 16'h0, 0));
      for (int i = 0; i < 8; i++) step(mk(0, 1, 16'h0C00 + 16'(i), 0, 0, 16'h0, 0));
      for (int i = 0; i < 65535; i++) step(mk(0, 1, 16'(i), 0, 1, 16'h0700, 0));
      chk("sat_tx_reach", tx_ovf_cnt, STATS ? 16'hFFFF : 16'h0);
      chk("sat_mis_reach", misroute_cnt, STATS ? 16'hFFFF : 16'h0);
      for (int i = 0; i < 3; i++) step(mk(0, 1, 16'h0D00, 0, 1, 16'h0700, 0));
      check_model("sat_hold");
      chk("sat_tx_hold", tx_ovf_cnt, STATS ? 16'hFFFF : 16'h0);
      chk("sat_mis_hold", misroute_cnt, STATS ? 16'hFFFF : 16'h0);
      chk("sat_head_kept", D_pop, 16'h0C00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
